pipe_hazard_ctrl: RTL

//  Sequences the front-end pipeline registers: generates load enables for the PC and IF/ID,
//  and the IF/ID clear strobe. Also generates the ID/EX bubble. Detects load-use hazards,

---
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard sequencer: load-use stalls, redirect flushes and syscall halt for PC, IF/ID and ID/EX.
// Optional HAZ_PERF_EN macro adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES      = 2,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       redirect,
  input  logic       halt_req,
  input  logic       go,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       pc_clear,
  output logic       id_ex_bubble,
  output logic       halted,
  output logic [1:0] state
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  if (FLUSH_CYCLES < 2 || FLUSH_CYCLES > 8) begin : g_bad_flush_cycles
    $error("pipe_hazard_ctrl: FLUSH_CYCLES must be in 2..8");
  end
  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_stall_cycles
    $error("pipe_hazard_ctrl: LOAD_STALL_CYCLES must be in 1..7");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // The accepting cycle (RUN/STALL) already drives one pc_clear or freeze cycle,
  // so the dedicated state only needs to cover the remaining N-1 cycles.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 2);
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 2);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       w_hazard;
  logic       w_redir_acc;

  assign w_hazard = ex_memread && (ex_rd != 5'd0) &&
                    ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_redir_acc  = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    pc_clear     = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (redirect) begin
          w_redir_acc = 1'b1;
        end else if (halt_req) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          w_state_nxt = S_HALT;
        end else if (w_hazard) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_state_nxt = S_STALL;
            w_cnt_nxt   = STALL_RELOAD;
          end
        end
      end
      S_STALL: begin
        if (redirect) begin
          w_redir_acc = 1'b1;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          if (r_cnt == 3'd0) w_state_nxt = S_RUN;
          else               w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      S_FLUSH: begin
        // halt_req and hazards belong to wrong-path instructions here
        pc_clear     = 1'b1;
        id_ex_bubble = 1'b1;
        if (redirect)            w_redir_acc = 1'b1;
        else if (r_cnt == 3'd0)  w_state_nxt = S_RUN;
        else                     w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_HALT: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        halted       = 1'b1;
        if (go) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (w_redir_acc) begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      pc_clear     = 1'b1;
      id_ex_bubble = 1'b1;
      w_state_nxt  = S_FLUSH;
      w_cnt_nxt    = FLUSH_RELOAD;
    end
  end

  assign state = r_state;

`ifdef HAZ_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (!pc_en && (r_state != S_HALT) && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_redir_acc && (r_perf_flush != 32'hFFFF_FFFF))
        r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule
